wb_pipe_responder: RTL and testbench

Pipelined Wishbone B4 slave that serves the CPU core's pipelined master port as a word-addressed, byte-maskable on-chip memory with fixed response latency. Sits behind the shared bus decoder as a slave, the responder counterpart of the core's pipelined initiator. It accepts one request per cycle, acknowledges in order after a programmable latency, and throttles the master with `wb_stall` when the outstanding-request limit is reached.

---
 rtl/wb_pipe_responder.sv | 99 +++++++++
 tb/tb_wb_pipe_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_responder.sv
// rtl/wb_pipe_responder.sv - pipelined Wishbone B4 slave memory with fixed-latency in-order acks
// and an outstanding-request limit that drives wb_stall.
module wb_pipe_responder #(
   parameter int adr_bits        = 10,
   parameter int latency         = 2,
   parameter int max_outstanding = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] wb_in,
   output logic [31:0] wb_out,
   input  logic [31:0] wb_adr,
   input  logic [3:0]  wb_sel,
   input  logic        wb_wren,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   output logic        wb_ack,
   output logic        wb_stall
);
   localparam int CW    = $clog2(max_outstanding + 1);
   localparam int DEPTH = 1 << adr_bits;

   logic [31:0]         mem_q [DEPTH];
   logic [31:0]         dat_q [latency];
   logic [latency-1:0]  vld_q, vld_d;
   logic [latency-1:0]  wr_q, wr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                rdy_q;
   logic [adr_bits-1:0] widx;
   logic                full;
   logic                accept;
   logic                unused_adr;

   assign widx       = wb_adr[adr_bits+1:2];
   assign unused_adr = ^{wb_adr[31:adr_bits+2], wb_adr[1:0]};

   // rdy_q releases one edge after rstn rises, so the first accept lands on the second edge.
   assign full     = (cnt_q == CW'(max_outstanding));
   assign wb_stall = rstn & wb_cyc & (full | ~rdy_q);
   assign accept   = wb_cyc & wb_stb & ~wb_stall & rdy_q;

   assign wb_ack = vld_q[latency-1] & wb_cyc;
   assign wb_out = (wb_ack & ~wr_q[latency-1]) ? dat_q[latency-1] : 32'h0;

   always_comb begin
      vld_d = '0;
      wr_d  = '0;
      if (wb_cyc) begin
         vld_d[0] = accept;
         wr_d[0]  = wb_wren;
         for (int i = 1; i < latency; i++) begin
            vld_d[i] = vld_q[i-1];
            wr_d[i]  = wr_q[i-1];
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!wb_cyc) begin
         cnt_d = '0;
      end else if (accept && !wb_ack) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!accept && wb_ack) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         vld_q <= vld_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         rdy_q <= 1'b1;
      end
   end

   // Storage and read data carry no reset; validity is tracked by vld_q alone.
   always_ff @(posedge clk) begin
      if (accept && wb_wren) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel[b]) begin
               mem_q[widx][8*b +: 8] <= wb_in[8*b +: 8];
            end
         end
      end
      if (accept && !wb_wren) begin
         dat_q[0] <= mem_q[widx];
      end
      for (int i = 1; i < latency; i++) begin
         dat_q[i] <= dat_q[i-1];
      end
   end
endmodule

// File: tb/tb_wb_pipe_responder.sv
// tb/tb_wb_pipe_responder.sv - four differently sized responders share one stimulus stream and
// are each checked every cycle against a queue-based model plus literal directed expectations.
module tb_wb_pipe_responder;
   localparam int N = 4;
   localparam logic [N-1:0][3:0] LATS = {4'd1, 4'd8, 4'd4, 4'd2};
   localparam logic [N-1:0][3:0] MOS  = {4'd1, 4'd8, 4'd2, 4'd4};

   logic        clk = 1'b0;
   logic        rstn, cyc, stb, wren;
   logic [31:0] din, adr;
   logic [3:0]  sel;
   logic [N-1:0] ack, stall;
   logic [31:0] dout [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      wb_pipe_responder #(
         .adr_bits(10),
         .latency(int'(LATS[g])),
         .max_outstanding(int'(MOS[g]))
      ) u_dut (
         .clk(clk),
         .rstn(rstn),
         .wb_in(din),
         .wb_out(dout[g]),
         .wb_adr(adr),
         .wb_sel(sel),
         .wb_wren(wren),
         .wb_cyc(cyc),
         .wb_stb(stb),
         .wb_ack(ack[g]),
         .wb_stall(stall[g])
      );
   end

   typedef struct {
      int          due;
      logic        wr;
      logic [31:0] data;
      logic [31:0] mask;
   } ent_t;

   ent_t        pq [N][$];
   logic [31:0] mmem [N][1024];
   logic [31:0] mknown [N][1024];
   int          ecount = 0;
   int          rel = 0;
   int          total = 0;
   int          bad = 0;
   int          ack_cnt [N];
   logic [N-1:0] stall_seen;
   logic [31:0] last_rd [N];
   logic [N-1:0] got;

   always @(posedge clk) ecount <= ecount + 1;

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, g, $time, act, exp);
      end
   endtask

   // Model: each accept becomes a queue entry due to ack `latency` edges later.
   initial begin
      for (int g = 0; g < N; g++) begin
         ack_cnt[g] = 0;
         last_rd[g] = 32'h0;
         for (int w = 0; w < 1024; w++) mknown[g][w] = 32'h0;
      end
      stall_seen = '0;
      got = '0;
      forever begin
         @(negedge clk);
         for (int g = 0; g < N; g++) begin
            int          lat, mo, cnt, w;
            logic        eack, estall, acc, erd;
            logic [31:0] eout, emask;
            ent_t        e;
            lat    = int'(LATS[g]);
            mo     = int'(MOS[g]);
            cnt    = pq[g].size();
            eack   = rstn && cyc && cnt > 0 && pq[g][0].due == ecount;
            estall = rstn && cyc && (cnt == mo || rel == 0);
            erd    = eack && !pq[g][0].wr;
            eout   = erd ? pq[g][0].data : 32'h0;
            emask  = erd ? pq[g][0].mask : 32'hFFFF_FFFF;
            chk("ack", g, 32'(ack[g]), 32'(eack));
            chk("stall", g, 32'(stall[g]), 32'(estall));
            chk("rdata", g, dout[g] & emask, eout & emask);
            if (ack[g]) ack_cnt[g]++;
            if (stall[g]) stall_seen[g] = 1'b1;
            if (ack[g] && erd) last_rd[g] = dout[g];
            acc = rstn && cyc && stb && !estall;
            if (!rstn || !cyc) begin
               pq[g].delete();
            end else begin
               if (eack) void'(pq[g].pop_front());
               if (acc) begin
                  w = int'(adr[11:2]);
                  e.due = ecount + lat;
                  e.wr  = wren;
                  if (wren) begin
                     for (int b = 0; b < 4; b++) begin
                        if (sel[b]) begin
                           mmem[g][w][8*b +: 8]   = din[8*b +: 8];
                           mknown[g][w][8*b +: 8] = 8'hFF;
                        end
                     end
                     e.data = 32'h0;
                     e.mask = 32'h0;
                  end else begin
                     e.data = mmem[g][w];
                     e.mask = mknown[g][w];
                  end
                  pq[g].push_back(e);
                  got[g] = 1'b1;
               end
            end
         end
         if (!rstn) rel = 0;
         else if (rel < 2) rel++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      cyc = 1'b1;
      stb = 1'b0;
      repeat (n) step();
   endtask

   task automatic idle(input int n);
      cyc = 1'b0;
      stb = 1'b0;
      repeat (n) step();
   endtask

   // Holds a request until every instance in `need` has taken it; repeats by others are idempotent.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] sl, input logic [N-1:0] need);
      got  = '0;
      cyc  = 1'b1;
      stb  = 1'b1;
      wren = w;
      adr  = a;
      din  = d;
      sel  = sl;
      for (int k = 0; k < 40; k++) begin
         step();
         if ((got & need) == need) break;
      end
      chk("accept", 0, 32'(got & need), 32'(need));
      stb = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; cyc = 1'b1; stb = 1'b1; wren = 1'b0;
      adr = 32'h0; din = 32'h0; sel = 4'h0;
      repeat (3) step();
      for (int g = 0; g < N; g++) begin
         chk("rst_ack", g, 32'(ack[g]), 32'h0);
         chk("rst_stall", g, 32'(stall[g]), 32'h0);
         chk("rst_out", g, dout[g], 32'h0);
      end
      rstn = 1'b1;
      idle(3);

      cyc = 1'b1; stb = 1'b1; wren = 1'b1; adr = 32'h10; din = 32'hDEAD_BEEF; sel = 4'hF;
      step();
      wren = 1'b0;
      step();
      @(negedge clk);
      chk("wr_ack_l2", 0, 32'(ack[0]), 32'h1);
      chk("wr_out_l2", 0, dout[0], 32'h0);
      @(posedge clk); #1;
      stb = 1'b0;
      @(negedge clk);
      chk("rd_ack_l2", 0, 32'(ack[0]), 32'h1);
      chk("rd_data_l2", 0, dout[0], 32'hDEAD_BEEF);
      @(negedge clk);
      @(negedge clk);
      chk("rd_ack_l4", 1, 32'(ack[1]), 32'h1);
      chk("rd_data_l4", 1, dout[1], 32'hDEAD_BEEF);
      step();
      drain(12);

      for (int g = 0; g < N; g++) last_rd[g] = 32'h0;
      issue(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, '1);
      issue(1'b1, 32'h20, 32'h0000_0000, 4'b0101, '1);
      issue(1'b0, 32'h20, 32'h0, 4'h0, '1);
      drain(12);
      for (int g = 0; g < N; g++) chk("bytemask", g, last_rd[g], 32'hFF00_FF00);

      for (int g = 0; g < N; g++) last_rd[g] = 32'h0;
      issue(1'b1, 32'h0000_1004, 32'hA5A5_5A5A, 4'hF, '1);
      issue(1'b0, 32'h0000_0004, 32'h0, 4'hF, '1);
      drain(12);
      for (int g = 0; g < N; g++) chk("alias", g, last_rd[g], 32'hA5A5_5A5A);

      idle(2);
      ack_cnt[1] = 0;
      stall_seen = '0;
      for (int i = 0; i < 6; i++) begin
         case (i % 3)
            0:       issue(1'b0, 32'h10, 32'h0, 4'hF, 4'b0010);
            1:       issue(1'b0, 32'h20, 32'h0, 4'hF, 4'b0010);
            default: issue(1'b0, 32'h04, 32'h0, 4'hF, 4'b0010);
         endcase
      end
      drain(16);
      chk("stall_acks", 1, 32'(ack_cnt[1]), 32'd6);
      chk("stall_seen", 1, 32'(stall_seen[1]), 32'h1);
      chk("stall_last", 1, last_rd[1], 32'hA5A5_5A5A);

      idle(2);
      ack_cnt[2] = 0;
      for (int i = 0; i < 3; i++) issue(1'b0, 32'h10, 32'h0, 4'hF, 4'b0100);
      cyc = 1'b0;
      step();
      drain(12);
      chk("abort_acks", 2, 32'(ack_cnt[2]), 32'd0);
      issue(1'b0, 32'h20, 32'h0, 4'hF, 4'b0100);
      drain(12);
      chk("fresh_acks", 2, 32'(ack_cnt[2]), 32'd1);
      chk("fresh_data", 2, last_rd[2], 32'hFF00_FF00);

      idle(2);
      cyc = 1'b1; stb = 1'b1; wren = 1'b0; adr = 32'h20;
      repeat (3) step();
      rstn = 1'b0;
      for (int g = 0; g < N; g++) ack_cnt[g] = 0;
      #1;
      for (int g = 0; g < N; g++) begin
         chk("midrst_ack", g, 32'(ack[g]), 32'h0);
         chk("midrst_stall", g, 32'(stall[g]), 32'h0);
         chk("midrst_out", g, dout[g], 32'h0);
      end
      step();
      stb = 1'b0;
      rstn = 1'b1;
      drain(14);
      for (int g = 0; g < N; g++) chk("postrst_acks", g, 32'(ack_cnt[g]), 32'd0);

      for (int c = 0; c < 1500; c++) begin
         cyc  = ($urandom_range(0, 19) != 0);
         stb  = ($urandom_range(0, 9) < 7);
         wren = ($urandom_range(0, 2) == 0);
         adr  = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
         sel  = 4'($urandom());
         din  = $urandom();
         rstn = ($urandom_range(0, 399) != 0);
         step();
      end
      rstn = 1'b1;
      drain(12);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
